write_mem_stage: RTL and testbench

Store-side pipeline stage that follows the memory-read stage: accepts a store from the instruction bundle stream, formats byte enables and lane-aligned data, and buffers it in a small in-order store queue. The queue drains to data memory over a valid/ready write port. Non-store instructions pass through with one cycle of latency. The stage stalls upstream when the queue is full.

---
 rtl/write_mem_stage.sv | 144 ++++++++++++++
 tb/tb_write_mem_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_mem_stage.sv
// Store-side pipeline stage: formats stores into lane-aligned words with byte
// enables, buffers them in an in-order circular store queue that drains over a
// valid/ready write port, and passes every accepted bundle through with one
// cycle of latency.

package stage;
   typedef struct packed {
      logic        valid;
      logic [29:0] addr;
      logic [31:0] insn;
   } InsnBundle;
endpackage

module write_mem_stage #(
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  stage::InsnBundle      insn,
   input  logic                  is_store,
   input  logic [ADDR_WIDTH-1:0] st_addr,
   input  logic [31:0]           st_data,
   input  logic [1:0]            st_size,
   output logic                  stall,
   output stage::InsnBundle      stage_out_insn,
   output logic                  misalign,
   output logic                  mem_wr_valid,
   input  logic                  mem_wr_ready,
   output logic [ADDR_WIDTH-3:0] mem_wr_addr,
   output logic [31:0]           mem_wr_data,
   output logic [3:0]            mem_wr_be,
   output logic                  sq_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [ADDR_WIDTH-3:0] q_addr [DEPTH];
   logic [31:0]           q_data [DEPTH];
   logic [3:0]            q_be   [DEPTH];

   logic [PW:0]      count_q, count_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   stage::InsnBundle out_q;
   logic             misalign_q;

   logic        accept, enq, deq, illegal;
   logic [1:0]  off;
   logic [3:0]  be_fmt;
   logic [31:0] data_fmt;

   // Stall looks only at registered count, never at mem_wr_ready.
   assign stall        = insn.valid && is_store && (count_q == FULL_CNT);
   assign accept       = insn.valid && !stall;
   assign enq          = accept && is_store && !illegal;
   assign mem_wr_valid = (count_q != '0);
   assign deq          = mem_wr_valid && mem_wr_ready;
   assign sq_empty     = (count_q == '0);
   assign off          = st_addr[1:0];

   // Legality check and lane formatting of the incoming store.
   always_comb begin
      illegal  = 1'b0;
      be_fmt   = 4'hF;
      data_fmt = st_data;
      unique case (st_size)
         2'd0: begin
            be_fmt   = 4'b0001 << off;
            data_fmt = {4{st_data[7:0]}};
         end
         2'd1: begin
            illegal  = off[0];
            be_fmt   = 4'b0011 << off;
            data_fmt = {2{st_data[15:0]}};
         end
         2'd2: begin
            illegal  = (off != 2'd0);
         end
         default: begin
            illegal  = 1'b1;
         end
      endcase
   end

   // Next-state for queue occupancy and pointers.
   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({enq, deq})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Queue control registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Queue storage; contents are don't-care until counted valid.
   always_ff @(posedge clk) begin
      if (enq) begin
         q_addr[wr_ptr_q] <= st_addr[ADDR_WIDTH-1:2];
         q_data[wr_ptr_q] <= data_fmt;
         q_be[wr_ptr_q]   <= be_fmt;
      end
   end

   // Pass-through bundle register and misalign pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q      <= '0;
         misalign_q <= 1'b0;
      end else begin
         out_q.valid <= accept;
         if (accept) begin
            out_q.addr <= insn.addr;
            out_q.insn <= insn.insn;
         end
         misalign_q <= accept && is_store && illegal;
      end
   end

   assign stage_out_insn = out_q;
   assign misalign       = misalign_q;
   assign mem_wr_addr    = mem_wr_valid ? q_addr[rd_ptr_q] : '0;
   assign mem_wr_data    = mem_wr_valid ? q_data[rd_ptr_q] : '0;
   assign mem_wr_be      = mem_wr_valid ? q_be[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_write_mem_stage.sv
// Bench for write_mem_stage: a queue-based reference model checked every
// cycle, plus literal expectations for formatting, stall and reset behaviour.

module tb_write_mem_stage;
   localparam int AW    = 32;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   stage::InsnBundle insn;
   logic             is_store;
   logic [AW-1:0]    st_addr;
   logic [31:0]      st_data;
   logic [1:0]       st_size;
   logic             stall;
   stage::InsnBundle so;
   logic             misalign;
   logic             mem_wr_valid;
   logic             mem_wr_ready;
   logic [AW-3:0]    mem_wr_addr;
   logic [31:0]      mem_wr_data;
   logic [3:0]       mem_wr_be;
   logic             sq_empty;

   write_mem_stage #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .insn(insn), .is_store(is_store),
      .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
      .stall(stall), .stage_out_insn(so), .misalign(misalign),
      .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_wr_be(mem_wr_be), .sq_empty(sq_empty)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int n_issued = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of pending memory writes.
   typedef struct {
      logic [AW-3:0] a;
      logic [31:0]   d;
      logic [3:0]    be;
   } wr_t;

   wr_t         mq[$];
   logic        m_ov, m_mis, m_stalled_last;
   logic [29:0] m_oa;
   logic [31:0] m_oi;
   bit          m_st, m_acc, m_legal;

   function automatic bit legal_f(logic [1:0] sz, logic [AW-1:0] a);
      return (sz == 0) || (sz == 1 && (a % 2) == 0) || (sz == 2 && (a % 4) == 0);
   endfunction

   function automatic wr_t fmt(logic [AW-1:0] a, logic [31:0] d, logic [1:0] sz);
      wr_t w;
      int  o;
      o   = int'(a % 4);
      w.a = (AW-2)'(a / 4);
      if (sz == 0) begin
         w.be = 4'(1 << o);
         w.d  = (d & 32'hFF) * 32'h0101_0101;
      end else if (sz == 1) begin
         w.be = 4'(3 << o);
         w.d  = (d & 32'hFFFF) * 32'h0001_0001;
      end else begin
         w.be = 4'hF;
         w.d  = d;
      end
      return w;
   endfunction

   function automatic bit m_stall();
      return insn.valid && is_store && (mq.size() == DEPTH);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_ov = 0; m_oa = 0; m_oi = 0; m_mis = 0; m_stalled_last = 0;
      end else begin
         m_st    = m_stall();
         m_acc   = insn.valid && !m_st;
         m_legal = legal_f(st_size, st_addr);
         if (mq.size() != 0 && mem_wr_ready) void'(mq.pop_front());
         if (m_acc && is_store && m_legal) mq.push_back(fmt(st_addr, st_data, st_size));
         m_ov = m_acc;
         if (m_acc) begin
            m_oa = insn.addr;
            m_oi = insn.insn;
         end
         m_mis          = m_acc && is_store && !m_legal;
         m_stalled_last = m_st;
      end
   end

   always @(posedge clk) if (rst && mem_wr_valid && mem_wr_ready) n_issued++;

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("stall", stall, m_stall());
      chk("out_valid", so.valid, m_ov);
      chk("out_addr", so.addr, m_oa);
      chk("out_insn", so.insn, m_oi);
      chk("misalign", misalign, m_mis);
      chk("wr_valid", mem_wr_valid, mq.size() != 0);
      chk("sq_empty", sq_empty, mq.size() == 0);
      if (mq.size() != 0) begin
         chk("head_addr", mem_wr_addr, mq[0].a);
         chk("head_data", mem_wr_data, mq[0].d);
         chk("head_be", mem_wr_be, mq[0].be);
      end else begin
         chk("idle_addr", mem_wr_addr, 0);
         chk("idle_data", mem_wr_data, 0);
         chk("idle_be", mem_wr_be, 0);
      end
   end

   task automatic put(input bit v, input bit s, input logic [29:0] ia,
                      input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      insn.valid = v;
      insn.addr  = ia;
      insn.insn  = $urandom;
      is_store   = s;
      st_addr    = a;
      st_data    = d;
      st_size    = sz;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k, cyc, base;
      logic [31:0] bad_a [3];
      logic [1:0]  bad_s [3];

      insn = '0; is_store = 0; st_addr = 0; st_data = 0; st_size = 0;
      mem_wr_ready = 1;

      // Reset held with traffic present.
      put(1, 1, 30'h5, 32'h1000, 32'h11, 2);
      tick(); tick();
      chk("rst_out_valid", so.valid, 0);
      chk("rst_misalign", misalign, 0);
      chk("rst_wr_valid", mem_wr_valid, 0);
      chk("rst_sq_empty", sq_empty, 1);
      chk("rst_be", mem_wr_be, 0);
      rst = 1;
      put(1, 0, 30'h10, 0, 0, 0);
      tick();
      chk("nop_valid", so.valid, 1);
      chk("nop_addr", so.addr, 30'h10);
      chk("nop_wr_valid", mem_wr_valid, 0);
      put(0, 0, 0, 0, 0, 0);
      tick();

      // Formatting with the memory always ready.
      put(1, 1, 30'h1, 32'h1003, 32'hAB, 0);
      tick();
      chk("sb_valid", mem_wr_valid, 1);
      chk("sb_be", mem_wr_be, 4'b1000);
      chk("sb_data", mem_wr_data, 32'hABABABAB);
      chk("sb_addr", mem_wr_addr, 30'h400);
      put(1, 1, 30'h2, 32'h2002, 32'h1234, 1);
      tick();
      chk("sh_be", mem_wr_be, 4'b1100);
      chk("sh_data", mem_wr_data, 32'h12341234);
      chk("sh_addr", mem_wr_addr, 30'h800);
      put(1, 1, 30'h3, 32'h3000, 32'hDEADBEEF, 2);
      tick();
      chk("sw_be", mem_wr_be, 4'hF);
      chk("sw_data", mem_wr_data, 32'hDEADBEEF);
      chk("sw_addr", mem_wr_addr, 30'hC00);
      put(0, 0, 0, 0, 0, 0);
      tick(); tick();
      chk("fmt_drained", sq_empty, 1);

      // Illegal stores.
      bad_a[0] = 32'h1001; bad_s[0] = 2;
      bad_a[1] = 32'h1003; bad_s[1] = 1;
      bad_a[2] = 32'h1000; bad_s[2] = 3;
      for (int i = 0; i < 3; i++) begin
         put(1, 1, 30'(i + 8), bad_a[i], 32'h5555, bad_s[i]);
         tick();
         chk("mis_pulse", misalign, 1);
         chk("mis_out_valid", so.valid, 1);
         chk("mis_no_write", mem_wr_valid, 0);
      end
      put(0, 0, 0, 0, 0, 0);
      tick();
      chk("mis_clear", misalign, 0);

      // Fill to full under backpressure.
      mem_wr_ready = 0;
      for (int i = 1; i <= 4; i++) begin
         put(1, 1, 30'(i), 32'(i * 32'h100), 32'(i), 2);
         tick();
      end
      put(1, 1, 30'h5, 32'h500, 32'h5, 2);
      #1;
      chk("full_stall", stall, 1);
      chk("full_head", mem_wr_addr, 30'h40);
      tick();
      chk("full_bubble", so.valid, 0);
      chk("full_stall_hold", stall, 1);
      chk("head_stable", mem_wr_addr, 30'h40);
      chk("head_stable_d", mem_wr_data, 32'h1);
      mem_wr_ready = 1;
      #1;
      chk("stall_conservative", stall, 1);
      tick();
      mem_wr_ready = 0;
      #1;
      chk("stall_drop", stall, 0);
      chk("head_after_deq", mem_wr_addr, 30'h80);
      tick();
      chk("fifth_accept", so.valid, 1);
      chk("fifth_addr", so.addr, 30'h5);
      put(0, 0, 0, 0, 0, 0);
      mem_wr_ready = 1;
      for (int i = 2; i <= 5; i++) begin
         chk("drain_addr", mem_wr_addr, 30'(i * 32'h40));
         chk("drain_data", mem_wr_data, 32'(i));
         tick();
      end
      chk("drain_empty", sq_empty, 1);

      // Stream with ready toggling: wrap plus simultaneous enq/deq.
      base = n_issued;
      k = 0; cyc = 0;
      while (k < 10 && cyc < 200) begin
         mem_wr_ready = (cyc % 2 == 0);
         put(1, 1, 30'(k), 32'(32'h4000 + 4 * k), 32'(32'h1000 + k), 2);
         tick();
         if (!m_stalled_last) k++;
         cyc++;
      end
      chk("wrap_done", k, 10);
      put(0, 0, 0, 0, 0, 0);
      mem_wr_ready = 1;
      repeat (8) tick();
      chk("wrap_issued", n_issued - base, 10);
      chk("wrap_drained", sq_empty, 1);

      // Asynchronous reset between edges while stores are queued.
      mem_wr_ready = 0;
      for (int i = 0; i < 3; i++) begin
         put(1, 1, 30'(i), 32'(32'h6000 + 4 * i), 32'(i), 2);
         tick();
      end
      put(0, 0, 0, 0, 0, 0);
      chk("pre_rst_valid", mem_wr_valid, 1);
      #2 rst = 0;
      #1;
      chk("arst_wr_valid", mem_wr_valid, 0);
      chk("arst_sq_empty", sq_empty, 1);
      chk("arst_be", mem_wr_be, 0);
      tick();
      rst = 1;
      mem_wr_ready = 1;
      base = n_issued;
      repeat (4) tick();
      chk("no_stale_write", n_issued - base, 0);

      // Randomized traffic, holding inputs while stalled.
      repeat (400) begin
         if (!m_stalled_last)
            put(($urandom % 4) != 0, ($urandom % 3) != 0, 30'($urandom), $urandom,
                $urandom, 2'($urandom % 4));
         mem_wr_ready = ($urandom % 3) != 0;
         tick();
      end
      put(0, 0, 0, 0, 0, 0);
      mem_wr_ready = 1;
      repeat (10) tick();
      chk("final_empty", sq_empty, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
